// File: rtl/aes_enc_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : aes_enc_round_ctrl
// Purpose  : Iterative AES-128 encryption sequencer driving one shared
//            combinational round unit for ten rounds per block.
// Revision : 1.0 - initial release
// ============================================================================
module aes_enc_round_ctrl (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    plain_in,
    input  logic [1407:0]   expanded_key,
    output logic [127:0]    rnd_state_o,
    output logic [127:0]    rnd_key_o,
    output logic            rnd_final_o,
    input  logic [127:0]    rnd_state_i,
    output logic [3:0]      rnd_idx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    cipher_text,
    output logic            busy
);

    localparam int         NUM_ROUNDS = 10;
    localparam logic [3:0] LAST_ROUND = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                     state_q;
    logic [3:0]                 cnt_q;
    logic [3:0]                 cnt_d;
    logic [127:0]               data_q;
    logic [128*NUM_ROUNDS-1:0]  key_q;
    logic                       in_ready_q;
    logic                       out_valid_q;
    logic                       busy_q;
    logic                       final_q;

    assign cnt_d = cnt_q + 4'd1;

    // Round key 0 is consumed at acceptance, so only rounds 1..10 are kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            key_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            final_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        state_q    <= S_ROUND;
                        data_q     <= plain_in ^ expanded_key[127:0];
                        key_q      <= expanded_key[1407:128];
                        cnt_q      <= 4'd1;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        final_q    <= 1'b0;
                    end
                end
                S_ROUND: begin
                    data_q <= rnd_state_i;
                    if (cnt_q == LAST_ROUND) begin
                        state_q     <= S_DONE;
                        cnt_q       <= '0;
                        final_q     <= 1'b0;
                        out_valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_d;
                        final_q <= (cnt_d == LAST_ROUND);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    final_q     <= 1'b0;
                end
            endcase
        end
    end

    // Counter values outside 1..10 select no key, so IDLE/DONE drive zero.
    always_comb begin
        rnd_key_o = '0;
        for (int k = 1; k <= NUM_ROUNDS; k++) begin
            if ((state_q == S_ROUND) && (cnt_q == 4'(k))) begin
                rnd_key_o = key_q[128*(k-1) +: 128];
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign busy        = busy_q;
    assign rnd_final_o = final_q;
    assign rnd_idx     = cnt_q;
    assign rnd_state_o = data_q;
    assign cipher_text = data_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_enc_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_enc_round_ctrl
// Purpose  : Directed bench for aes_enc_round_ctrl with an AES round model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_enc_round_ctrl;

    localparam logic [127:0] K_C1  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] P_C1  = 128'hffeeddccbbaa99887766554433221100;
    localparam logic [127:0] CT_C1 = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
    localparam logic [127:0] K_B   = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] P_B   = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] CT_B  = 128'h320b6a19978511dcfb09dc021d842539;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [127:0]    plain_in = '0;
    logic [1407:0]   expanded_key = '0;
    logic [127:0]    rnd_state_o;
    logic [127:0]    rnd_key_o;
    logic            rnd_final_o;
    logic [127:0]    rnd_state_i;
    logic [3:0]      rnd_idx;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [127:0]    cipher_text;
    logic            busy;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    aes_enc_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .plain_in     (plain_in),
        .expanded_key (expanded_key),
        .rnd_state_o  (rnd_state_o),
        .rnd_key_o    (rnd_key_o),
        .rnd_final_o  (rnd_final_o),
        .rnd_state_i  (rnd_state_i),
        .rnd_idx      (rnd_idx),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cipher_text  (cipher_text),
        .busy         (busy)
    );

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box from the GF(2^8) inverse (a^254) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] inv;
        logic [7:0] r;
        logic [7:0] s;
        sq  = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        r = inv;
        s = inv;
        for (int i = 0; i < 4; i++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(st[8*i +: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            if (fin) begin
                for (int r = 0; r < 4; r++) o[8*(4*c+r) +: 8] = t[4*c+r];
            end else begin
                o[8*(4*c)   +: 8] = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
                o[8*(4*c+1) +: 8] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
                o[8*(4*c+2) +: 8] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
                o[8*(4*c+3) +: 8] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
            end
        end
        return o ^ rk;
    endfunction

    function automatic logic [1407:0] key_exp(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] e;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = {t[7:0], t[31:8]};
                t  = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {24'h0, rc};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) e[32*i +: 32] = w[i];
        return e;
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [1407:0] ek);
        logic [127:0] s;
        s = pt ^ ek[127:0];
        for (int r = 1; r <= 10; r++) s = aes_round(s, ek[128*r +: 128], r == 10);
        return s;
    endfunction

    assign rnd_state_i = aes_round(rnd_state_o, rnd_key_o, rnd_final_o);

    // Starts in an IDLE cycle (#1 after an edge); leaves the DUT back in IDLE.
    task automatic do_block(input string name, input logic [127:0] pt, input logic [127:0] key,
                            input logic [127:0] exp_ct, input int stall, input int zero_at);
        logic [1407:0] ek;
        ek = key_exp(key);
        vecs++;
        if (in_ready !== 1'b1) begin
            errs++;
            $display("FAIL %s idle_ready: in_ready=%b required 1", name, in_ready);
        end
        plain_in     = pt;
        expanded_key = ek;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        plain_in = {$urandom, $urandom, $urandom, $urandom};
        for (int r = 1; r <= 10; r++) begin
            if (r == zero_at) expanded_key = '0;
            vecs++;
            if ({rnd_idx, rnd_final_o, out_valid, in_ready, busy} !== {4'(r), (r == 10), 3'b001} ||
                rnd_key_o !== ek[128*r +: 128]) begin
                errs++;
                $display("FAIL %s round%0d: idx=%0d fin=%b ov=%b ir=%b busy=%b key=%h required idx=%0d fin=%b key=%h",
                         name, r, rnd_idx, rnd_final_o, out_valid, in_ready, busy, rnd_key_o,
                         r, (r == 10), ek[128*r +: 128]);
            end
            @(posedge clk); #1;
        end
        for (int s = 0; s <= stall; s++) begin
            vecs++;
            if ({out_valid, busy, in_ready, rnd_idx, rnd_final_o} !== {3'b110, 4'd0, 1'b0} ||
                cipher_text !== exp_ct || rnd_key_o !== 128'h0) begin
                errs++;
                $display("FAIL %s done%0d: ov=%b busy=%b ir=%b idx=%0d ct=%h required ov=1 busy=1 ir=0 idx=0 ct=%h",
                         name, s, out_valid, busy, in_ready, rnd_idx, cipher_text, exp_ct);
            end
            if (s == stall) out_ready = 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        vecs++;
        if ({in_ready, busy, out_valid} !== 3'b100) begin
            errs++;
            $display("FAIL %s back_idle: ir=%b busy=%b ov=%b required 1 0 0", name, in_ready, busy, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        // Acceptance offered while reset is held must be ignored.
        in_valid = 1'b1;
        plain_in = P_C1;
        expanded_key = key_exp(K_C1);
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
        vecs++;
        if ({out_valid, busy} !== 2'b00) begin errs++; $display("FAIL rst_ov_busy: got %b%b required 00", out_valid, busy); end
        vecs++;
        if (cipher_text !== 128'h0) begin errs++; $display("FAIL rst_cipher: got %h required 0", cipher_text); end
        vecs++;
        if ({rnd_idx, rnd_final_o} !== 5'd0) begin errs++; $display("FAIL rst_idx: idx=%0d fin=%b required 0 0", rnd_idx, rnd_final_o); end
        vecs++;
        if (rnd_key_o !== 128'h0 || rnd_state_o !== 128'h0) begin
            errs++;
            $display("FAIL rst_rnd_bus: key=%h state=%h required 0 0", rnd_key_o, rnd_state_o);
        end
    endtask

    task automatic test_fips_c1();
        do_block("c1", P_C1, K_C1, CT_C1, 0, 0);
    endtask

    task automatic test_fips_b();
        do_block("fips_b", P_B, K_B, CT_B, 0, 0);
    endtask

    task automatic test_stall();
        do_block("stall20", P_C1, K_C1, CT_C1, 20, 0);
    endtask

    task automatic test_key_change();
        do_block("key_change", P_C1, K_C1, CT_C1, 0, 2);
    endtask

    task automatic test_back_to_back();
        logic [127:0]  pts  [3];
        logic [127:0]  exps [3];
        int            acc  [3];
        logic [1407:0] ek;
        logic [3:0]    exp_idx;
        int nacc;
        int nout;
        int cyc;
        ek   = key_exp(K_C1);
        pts[0] = P_C1;
        pts[1] = 128'h0;
        pts[2] = 128'h0123456789abcdeffedcba9876543210;
        exps[0] = CT_C1;
        exps[1] = aes_enc(pts[1], ek);
        exps[2] = aes_enc(pts[2], ek);
        nacc = 0; nout = 0; cyc = 0;
        exp_idx = 4'd0;
        expanded_key = ek;
        plain_in  = pts[0];
        out_ready = 1'b1;
        in_valid  = 1'b1;
        while (nout < 3 && cyc < 80) begin
            vecs++;
            if (rnd_idx !== exp_idx || rnd_final_o !== (exp_idx == 4'd10)) begin
                errs++;
                $display("FAIL b2b_idx cyc%0d: idx=%0d fin=%b required idx=%0d fin=%b",
                         cyc, rnd_idx, rnd_final_o, exp_idx, (exp_idx == 4'd10));
            end
            if (out_valid === 1'b1) begin
                vecs++;
                if (cipher_text !== exps[nout]) begin
                    errs++;
                    $display("FAIL b2b_ct%0d: got %h required %h", nout, cipher_text, exps[nout]);
                end
                nout++;
            end
            if (in_ready === 1'b1 && in_valid && nacc < 3) begin
                acc[nacc] = cyc;
                nacc++;
                exp_idx = 4'd1;
            end else if (exp_idx >= 4'd1 && exp_idx < 4'd10) begin
                exp_idx = exp_idx + 4'd1;
            end else begin
                exp_idx = 4'd0;
            end
            @(posedge clk); #1;
            cyc++;
            if (nacc < 3) plain_in = pts[nacc];
            else          in_valid = 1'b0;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        vecs++;
        if (nout != 3 || nacc != 3) begin
            errs++;
            $display("FAIL b2b_count: outputs=%0d accepts=%0d required 3 3", nout, nacc);
        end else begin
            for (int i = 1; i < 3; i++) begin
                vecs++;
                if (acc[i] - acc[i-1] != 12) begin
                    errs++;
                    $display("FAIL b2b_interval%0d: got %0d cycles required 12", i, acc[i] - acc[i-1]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_round();
        int  cyc;
        bit  seen;
        plain_in     = P_B;
        expanded_key = key_exp(K_B);
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (rnd_idx !== 4'd5 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        vecs++;
        if (rnd_idx !== 4'd5) begin
            errs++;
            $display("FAIL mid_reach5: idx=%0d required 5", rnd_idx);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vecs++;
        if ({in_ready, busy, out_valid, rnd_idx, rnd_final_o} !== {3'b100, 4'd0, 1'b0} ||
            cipher_text !== 128'h0) begin
            errs++;
            $display("FAIL mid_reset_state: ir=%b busy=%b ov=%b idx=%0d fin=%b ct=%h required 1 0 0 0 0 0",
                     in_ready, busy, out_valid, rnd_idx, rnd_final_o, cipher_text);
        end
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        vecs++;
        if (seen) begin
            errs++;
            $display("FAIL mid_no_output: out_valid seen=1 required 0");
        end
        do_block("after_reset", P_C1, K_C1, CT_C1, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fips_c1();
        test_fips_b();
        test_stall();
        test_key_change();
        test_back_to_back();
        test_reset_mid_round();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
`default_nettype wire
